// File: rtl/panel_input_if.sv
// Front-panel bundle: raw buttons/switches and panel values in, debounced
// levels, one-cycle strobes and captured register data out.
interface panel_input_if;
    logic [7:0]  btn_raw;
    logic [5:0]  switch_raw;
    logic [30:0] input_reg_c_value;
    logic [11:0] input_reg_select_value;
    logic [11:0] input_reg_start_value;
    logic        core_busy;

    logic        btn_machine_start;
    logic        btn_clear_pulse;
    logic        btn_do_read_mem;
    logic        btn_do_write_mem;
    logic        switch_auto_enable;
    logic        switch_stop_at_enable;
    logic        switch_select_or_start;
    logic [2:0]  do_arr_reg;
    logic [2:0]  do_clear_reg;
    logic [30:0] arr_reg_c_data;
    logic [11:0] arr_reg_select_data;
    logic [11:0] arr_reg_start_data;

    modport slave (
        input  btn_raw, switch_raw, input_reg_c_value, input_reg_select_value,
               input_reg_start_value, core_busy,
        output btn_machine_start, btn_clear_pulse, btn_do_read_mem, btn_do_write_mem,
               switch_auto_enable, switch_stop_at_enable, switch_select_or_start,
               do_arr_reg, do_clear_reg, arr_reg_c_data, arr_reg_select_data,
               arr_reg_start_data
    );

    modport master (
        output btn_raw, switch_raw, input_reg_c_value, input_reg_select_value,
               input_reg_start_value, core_busy,
        input  btn_machine_start, btn_clear_pulse, btn_do_read_mem, btn_do_write_mem,
               switch_auto_enable, switch_stop_at_enable, switch_select_or_start,
               do_arr_reg, do_clear_reg, arr_reg_c_data, arr_reg_select_data,
               arr_reg_start_data
    );
endinterface

// File: rtl/panel_input.sv
// Front-panel input conditioning: per-bit synchroniser and debouncer, rising-edge
// button pulses with post-reset arming, and register load/clear strobes.
module panel_input #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic         clk,
    input  logic         reset,
    panel_input_if.slave bus
);
    localparam int NBITS = 14;
    localparam int NBTN  = 8;
    localparam int CW    = 16;
    localparam int FW    = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(SYNC_STAGES);

    logic [NBITS-1:0] raw;
    logic [NBITS-1:0] synced;
    logic [NBITS-1:0] level;

    // Bits 0..7 are buttons, 8..13 are switches.
    assign raw = {bus.switch_raw, bus.btn_raw};

    genvar gi;
    generate
        for (gi = 0; gi < NBITS; gi++) begin : g_deb
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            logic [CW-1:0]          cnt_q, cnt_d;
            logic                   level_q, level_d;

            always_comb begin
                sync_d  = {sync_q[SYNC_STAGES-2:0], raw[gi]};
                cnt_d   = '0;
                level_d = level_q;
                if (sync_q[SYNC_STAGES-1] != level_q) begin
                    if (cnt_q == CNT_LAST) begin
                        level_d = sync_q[SYNC_STAGES-1];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_q  <= '0;
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                end else begin
                    sync_q  <= sync_d;
                    cnt_q   <= cnt_d;
                    level_q <= level_d;
                end
            end

            assign synced[gi] = sync_q[SYNC_STAGES-1];
            assign level[gi]  = level_q;
        end
    endgenerate

    logic [FW-1:0]   fill_q, fill_d;
    logic            filled;
    logic [NBTN-1:0] armed_q, armed_d;
    logic [NBTN-1:0] prev_q, prev_d;
    logic [NBTN-1:0] rise;
    logic [3:0]      pulse_q, pulse_d;
    logic [2:0]      arr_q, arr_d;
    logic [2:0]      clr_q, clr_d;
    logic [30:0]     c_data_q, c_data_d;
    logic [11:0]     sel_data_q, sel_data_d;
    logic [11:0]     st_data_q, st_data_d;

    // A button arms only once the synchroniser holds real samples and both its
    // synced and debounced values read released, so a press held through reset
    // must be let go before it can fire.
    always_comb begin
        filled     = (fill_q == FILL_FULL);
        fill_d     = filled ? fill_q : fill_q + 1'b1;
        armed_d    = armed_q | ({NBTN{filled}} & ~level[NBTN-1:0] & ~synced[NBTN-1:0]);
        prev_d     = level[NBTN-1:0];
        rise       = level[NBTN-1:0] & ~prev_q & armed_q;
        pulse_d    = rise[3:0];
        clr_d      = rise[7:5];
        arr_d      = {3{rise[4]}} & level[13:11] & ~clr_d;
        c_data_d   = arr_d[0] ? bus.input_reg_c_value      : c_data_q;
        sel_data_d = arr_d[1] ? bus.input_reg_select_value : sel_data_q;
        st_data_d  = arr_d[2] ? bus.input_reg_start_value  : st_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_q     <= '0;
            armed_q    <= '0;
            prev_q     <= '0;
            pulse_q    <= '0;
            arr_q      <= '0;
            clr_q      <= '0;
            c_data_q   <= '0;
            sel_data_q <= '0;
            st_data_q  <= '0;
        end else begin
            fill_q     <= fill_d;
            armed_q    <= armed_d;
            prev_q     <= prev_d;
            pulse_q    <= pulse_d;
            arr_q      <= arr_d;
            clr_q      <= clr_d;
            c_data_q   <= c_data_d;
            sel_data_q <= sel_data_d;
            st_data_q  <= st_data_d;
        end
    end

    // Start is dropped, not deferred, while the core is busy in the pulse cycle.
    assign bus.btn_machine_start      = pulse_q[0] & ~bus.core_busy;
    assign bus.btn_clear_pulse        = pulse_q[1];
    assign bus.btn_do_read_mem        = pulse_q[2];
    assign bus.btn_do_write_mem       = pulse_q[3];
    assign bus.switch_auto_enable     = level[8];
    assign bus.switch_stop_at_enable  = level[9];
    assign bus.switch_select_or_start = level[10];
    assign bus.do_arr_reg             = arr_q;
    assign bus.do_clear_reg           = clr_q;
    assign bus.arr_reg_c_data         = c_data_q;
    assign bus.arr_reg_select_data    = sel_data_q;
    assign bus.arr_reg_start_data     = st_data_q;
endmodule

// File: tb/tb_panel_input.sv
// Bench for panel_input: directed scenarios plus randomized inputs, all outputs
// compared every cycle against a history-window reference model.
module tb_panel_input;
    localparam int S = 2;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    panel_input_if ifc();

    panel_input #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state: raw samples taken at each edge since reset.
    logic [13:0] hist[$];
    int          k;
    logic [13:0] m_deb;
    logic [7:0]  m_prev, m_arm;
    logic [3:0]  m_pulse;
    logic [2:0]  m_arr, m_clr;
    logic [30:0] m_c;
    logic [11:0] m_sel, m_st;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] obs_vec();
        return {ifc.btn_machine_start, ifc.btn_clear_pulse, ifc.btn_do_read_mem,
                ifc.btn_do_write_mem, ifc.switch_auto_enable, ifc.switch_stop_at_enable,
                ifc.switch_select_or_start, ifc.do_arr_reg, ifc.do_clear_reg};
    endfunction

    function automatic logic [12:0] exp_vec();
        return {m_pulse[0] & ~ifc.core_busy, m_pulse[1], m_pulse[2], m_pulse[3],
                m_deb[8], m_deb[9], m_deb[10], m_arr, m_clr};
    endfunction

    // Synced value presented to the debouncer at edge j (1-based since reset).
    function automatic logic [13:0] sync_at(input int j);
        if (j - S - 1 >= 0) return hist[j-S-1];
        return '0;
    endfunction

    task automatic model_reset();
        hist.delete();
        k = 0; m_deb = '0; m_prev = '0; m_arm = '0; m_pulse = '0;
        m_arr = '0; m_clr = '0; m_c = '0; m_sel = '0; m_st = '0;
    endtask

    task automatic tick();
        logic [13:0] raw, nd, sp, sv;
        logic [7:0]  rise;
        bit          flip;
        raw = {ifc.switch_raw, ifc.btn_raw};
        if (reset) begin
            model_reset();
        end else begin
            k++;
            sp = sync_at(k);
            nd = m_deb;
            // A level flips once the synced input has disagreed with it on
            // each of the last D edges since reset.
            for (int b = 0; b < 14; b++) begin
                flip = (k - D + 1 >= 1);
                for (int j = k - D + 1; j <= k; j++) begin
                    if (j >= 1) begin
                        sv = sync_at(j);
                        if (sv[b] == m_deb[b]) flip = 0;
                    end
                end
                if (flip) nd[b] = ~m_deb[b];
            end
            rise    = m_deb[7:0] & ~m_prev & m_arm;
            m_pulse = rise[3:0];
            m_clr   = rise[7:5];
            m_arr   = {3{rise[4]}} & m_deb[13:11] & ~m_clr;
            if (m_arr[0]) m_c   = ifc.input_reg_c_value;
            if (m_arr[1]) m_sel = ifc.input_reg_select_value;
            if (m_arr[2]) m_st  = ifc.input_reg_start_value;
            if (k - S - 1 >= 0) m_arm = m_arm | (~m_deb[7:0] & ~sp[7:0]);
            m_prev = m_deb[7:0];
            m_deb  = nd;
            hist.push_back(raw);
        end
        @(posedge clk);
        #1;
        check("outs", 64'(obs_vec()), 64'(exp_vec()));
        check("data", {ifc.arr_reg_c_data, ifc.arr_reg_select_data, ifc.arr_reg_start_data},
              {m_c, m_sel, m_st});
    endtask

    initial begin
        int cnt, first;
        logic [2:0]  arr_seen, clr_seen;
        logic [30:0] c_seen;
        logic [11:0] st_seen;

        reset = 1'b1;
        ifc.btn_raw = '0; ifc.switch_raw = '0; ifc.core_busy = 1'b0;
        ifc.input_reg_c_value = '0; ifc.input_reg_select_value = 12'h0;
        ifc.input_reg_start_value = 12'hABC;
        model_reset();
        #1;
        check("reset_outs", 64'(obs_vec()), 64'h0);
        tick(); tick();
        reset = 1'b0;
        repeat (5) tick();
        $display("[TB] reset released");

        // Single start press, 7-cycle latency, one pulse.
        ifc.btn_raw[0] = 1'b1; cnt = 0; first = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ifc.btn_machine_start) begin cnt++; if (first < 0) first = i; end
        end
        check("start_count", 64'(cnt), 64'd1);
        check("start_latency", 64'(first), 64'd7);
        $display("[TB] start press: pulses=%0d at cycle %0d", cnt, first);
        ifc.btn_raw[0] = 1'b0; repeat (12) tick();

        // Short write_reg glitch, then a real press with C and start selected.
        ifc.btn_raw[4] = 1'b1; cnt = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 3) ifc.btn_raw[4] = 1'b0;
            if (ifc.do_arr_reg != 3'b000) cnt++;
        end
        check("glitch_no_strobe", 64'(cnt), 64'd0);
        ifc.switch_raw[3] = 1'b1; ifc.switch_raw[5] = 1'b1;
        ifc.input_reg_c_value = 31'h1234_5678;
        repeat (10) tick();
        ifc.btn_raw[4] = 1'b1; cnt = 0; arr_seen = '0; c_seen = '0; st_seen = '0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (ifc.do_arr_reg != 3'b000) begin
                cnt++; arr_seen = ifc.do_arr_reg;
                c_seen = ifc.arr_reg_c_data; st_seen = ifc.arr_reg_start_data;
            end
        end
        check("arr_count", 64'(cnt), 64'd1);
        check("arr_strobe", 64'(arr_seen), 64'h5);
        check("arr_c_data", 64'(c_seen), 64'h1234_5678);
        check("arr_start_data", 64'(st_seen), 64'hABC);
        check("arr_sel_untouched", 64'(ifc.arr_reg_select_data), 64'h0);
        $display("[TB] write_reg: strobes=%0d do_arr_reg=%b c=%h", cnt, arr_seen, c_seen);
        ifc.btn_raw[4] = 1'b0; repeat (12) tick();

        // Start while busy is dropped and not replayed after busy clears.
        ifc.core_busy = 1'b1; ifc.btn_raw[0] = 1'b1; cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ifc.btn_machine_start) cnt++;
            if (i == 9) ifc.core_busy = 1'b0;
        end
        check("busy_suppress", 64'(cnt), 64'd0);
        $display("[TB] start while busy: pulses=%0d", cnt);
        ifc.btn_raw[0] = 1'b0; repeat (12) tick();

        // Clear wins over a simultaneous load of the same register.
        ifc.switch_raw[5] = 1'b0; ifc.input_reg_c_value = 31'h0765_4321;
        repeat (10) tick();
        ifc.btn_raw[4] = 1'b1; ifc.btn_raw[5] = 1'b1;
        cnt = 0; clr_seen = '0; arr_seen = 3'b111;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (ifc.do_clear_reg != 3'b000) begin
                cnt++; clr_seen = ifc.do_clear_reg; arr_seen = ifc.do_arr_reg;
            end
        end
        check("clr_count", 64'(cnt), 64'd1);
        check("clr_strobe", 64'(clr_seen), 64'h1);
        check("clr_arr_blocked", 64'(arr_seen), 64'h0);
        check("clr_c_kept", 64'(ifc.arr_reg_c_data), 64'h1234_5678);
        $display("[TB] clear+write: do_clear_reg=%b do_arr_reg=%b", clr_seen, arr_seen);
        ifc.btn_raw[4] = 1'b0; ifc.btn_raw[5] = 1'b0; repeat (12) tick();

        // Button held across a reset pulse must be released before it fires.
        ifc.btn_raw[1] = 1'b1; repeat (3) tick();
        reset = 1'b1; model_reset(); #1;
        check("reset_async", 64'(obs_vec()), 64'h0);
        tick();
        reset = 1'b0; cnt = 0;
        for (int i = 1; i <= 15; i++) begin tick(); if (ifc.btn_clear_pulse) cnt++; end
        check("held_no_pulse", 64'(cnt), 64'd0);
        ifc.btn_raw[1] = 1'b0; repeat (10) tick();
        ifc.btn_raw[1] = 1'b1; cnt = 0;
        for (int i = 1; i <= 12; i++) begin tick(); if (ifc.btn_clear_pulse) cnt++; end
        check("repress_pulse", 64'(cnt), 64'd1);
        $display("[TB] held through reset: re-press pulses=%0d", cnt);
        ifc.btn_raw[1] = 1'b0; repeat (12) tick();

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(9) == 0) ifc.btn_raw[b] = ~ifc.btn_raw[b];
            for (int b = 0; b < 6; b++)
                if ($urandom_range(11) == 0) ifc.switch_raw[b] = ~ifc.switch_raw[b];
            ifc.core_busy = ($urandom_range(2) == 0);
            ifc.input_reg_c_value      = 31'($urandom);
            ifc.input_reg_select_value = 12'($urandom);
            ifc.input_reg_start_value  = 12'($urandom);
            if ($urandom_range(499) == 0) begin
                reset = 1'b1; model_reset(); #1;
                check("rand_reset", 64'(obs_vec()), 64'h0);
                tick();
                reset = 1'b0;
            end
            tick();
        end
        $display("[TB] random phase done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/panel_input.md
PANEL_INPUT -- requirements
Module: panel_input

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles a synced input needs before its debounced level changes; legal range 2..65535.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser flops per raw input; minimum 2.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 btn_raw  in  8  raw buttons, 1=pressed. Bits: 0 machine_start, 1 clear_pulse, 2 do_read_mem, 3 do_write_mem, 4 write_reg, 5 clear_reg_c, 6 clear_reg_select, 7 clear_reg_start.
REQ-006 switch_raw  in  6  raw switches, 1=on. Bits: 0 auto_enable, 1 stop_at_enable, 2 select_or_start, 3 arr_reg_c, 4 arr_reg_select, 5 arr_reg_start.
REQ-007 input_reg_c_value  in  31  panel value for C register; quasi-static.
REQ-008 input_reg_select_value  in  12  panel value for select register.
REQ-009 input_reg_start_value  in  12  panel value for start register.
REQ-010 core_busy  in  1  core is executing; gates machine_start.
REQ-011 btn_machine_start  out  1  one-cycle start pulse.
REQ-012 btn_clear_pulse  out  1  one-cycle pulse-counter clear.
REQ-013 btn_do_read_mem  out  1  one-cycle manual memory read.
REQ-014 btn_do_write_mem  out  1  one-cycle manual memory write.
REQ-015 switch_auto_enable, switch_stop_at_enable, switch_select_or_start  out  1 each  debounced levels of switch bits 0..2.
REQ-016 do_arr_reg  out  3  one-cycle load strobes; bit 0 C, 1 select, 2 start.
REQ-017 do_clear_reg  out  3  one-cycle clear strobes, same bit map.
REQ-018 arr_reg_c_data / arr_reg_select_data / arr_reg_start_data  out  31/12/12  panel values captured for do_arr_reg.

Function
REQ-019 Each btn_raw and switch_raw bit SHALL pass SYNC_STAGES flops, then an independent debouncer: per-bit counter cleared whenever synced value equals debounced level; else increments; at DEBOUNCE_CYCLES debounced level takes synced value and counter clears.
REQ-020 A synced glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change the debounced level.
REQ-021 Button pulse outputs SHALL assert exactly one cycle, the cycle after the debounced level rises 0->1; no pulse on 1->0; holding a button yields one pulse.
REQ-022 Press-to-pulse latency SHALL be SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles from raw stable edge.
REQ-023 Each button SHALL be armed only after its debounced level is seen 0 post-reset; a button held through reset release SHALL not pulse until released and re-pressed.
REQ-024 btn_machine_start SHALL be suppressed (dropped, not queued) when core_busy=1 in the cycle the pulse would assert.
REQ-025 write_reg pulse SHALL, in the same output cycle, assert do_arr_reg[i] for each debounced arr switch (bits 3..5) that is 1, and register the corresponding input_reg_*_value into arr_reg_*_data; data SHALL be valid while strobe high and hold until next capture.
REQ-026 write_reg with all arr switches 0 SHALL produce no strobe and leave data unchanged.
REQ-027 clear_reg_* pulses SHALL assert do_clear_reg bits 0/1/2 for one cycle.
REQ-028 If do_clear_reg[i] and do_arr_reg[i] would assert in the same cycle, clear SHALL win: do_arr_reg[i]=0, data for i unchanged.
REQ-029 Distinct buttons debouncing in the same cycle SHALL each produce their own pulse in that cycle.

Reset
REQ-030 On reset assertion, immediately and while held: all sync flops, debounced levels, counters, arm flags, strobes, pulses and levels = 0; arr_reg_*_data = 0. Mid-debounce progress SHALL be discarded.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-031 btn_raw[0] 0->1 held 20 cycles, core_busy=0 -> btn_machine_start high exactly once, 7 cycles after edge.
REQ-032 btn_raw[4] pulsed 3 cycles -> no output; then held with switch_raw[3]=1, [5]=1, input_reg_c_value=31'h1234_5678 -> do_arr_reg=3'b101 one cycle, arr_reg_c_data=31'h1234_5678.
REQ-033 btn_raw[0] pressed with core_busy=1 -> no btn_machine_start; core_busy drops while held -> still none.
REQ-034 btn_raw[4] and btn_raw[5] pressed same cycle, switch_raw[3]=1 -> do_clear_reg=3'b001, do_arr_reg=3'b000.
REQ-035 btn_raw[1] held across reset pulse mid-debounce -> no pulse after reset release; release 10 cycles, re-press -> one btn_clear_pulse.
